// File: rtl/concatenator_pkg.sv
// Shared constants and types for the ChaCha20 keystream collection buffer.
package concat_pkg;

    localparam int WORDS_PER_MATRIX = 64;
    localparam int DATA_SIZE        = 8;

    typedef logic [DATA_SIZE-1:0] concat_word_t;

endpackage : concat_pkg

// File: rtl/concatenator_addr_ctr.sv
// Write pointer, full flag and one-hot slot write enables for concatenator.
// Build option CONCATENATOR_WRAP_EN turns the sticky full into a one-cycle pulse with continuous wrap.
module concat_addr_ctr #(
    parameter int NO_REG = 128
) (
    input  logic              clk,
    input  logic              rst,
    output logic              full,
    output logic [NO_REG-1:0] wr_en
);
    import concat_pkg::*;

    localparam int PTR_W = $clog2(NO_REG);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NO_REG - 1);

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic              full_r;
    logic              full_nxt_s;
    logic              write_s;
    logic [NO_REG-1:0] wr_en_s;

    // Next pointer / full flag and the per-slot write decode
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        full_nxt_s   = full_r;
        write_s      = 1'b0;
        wr_en_s      = '0;
`ifdef CONCATENATOR_WRAP_EN
        // Streaming: every cycle writes; full only marks the slot that closes the array
        write_s = 1'b1;
        if (wr_ptr_r == LAST_PTR) begin
            wr_ptr_nxt_s = '0;
            full_nxt_s   = 1'b1;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            full_nxt_s   = 1'b0;
        end
`else
        if (!full_r) begin
            write_s = 1'b1;
            if (wr_ptr_r == LAST_PTR) begin
                wr_ptr_nxt_s = '0;
                full_nxt_s   = 1'b1;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
                full_nxt_s   = 1'b0;
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
            full_nxt_s   = 1'b1;
        end
`endif
        for (int i = 0; i < NO_REG; i++) begin
            wr_en_s[i] = write_s && (wr_ptr_r == PTR_W'(i));
        end
    end

    // Pointer and full flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            full_r   <= full_nxt_s;
        end
    end

    assign full  = full_r;
    assign wr_en = wr_en_s;

endmodule : concat_addr_ctr

// File: rtl/concatenator.sv
// Byte-serial collection buffer: captures one word per clock into a NUM_MATRICES*64 entry array.
// Build option CONCATENATOR_WRAP_EN selects continuous wrap-around streaming instead of sticky full.
module concatenator #(
    parameter int  DATA_SIZE    = concat_pkg::DATA_SIZE,
    parameter int  NUM_MATRICES = 2,
    localparam int NO_REG       = concat_pkg::WORDS_PER_MATRIX * NUM_MATRICES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] input_data_split,
    output logic                 full,
    output logic [DATA_SIZE-1:0] concatout [0:NO_REG-1]
);
    import concat_pkg::*;

    logic [NO_REG-1:0]    wr_en_s;
    logic [DATA_SIZE-1:0] storage_r [0:NO_REG-1];

    concat_addr_ctr #(
        .NO_REG (NO_REG)
    ) u_addr_ctr (
        .clk   (clk),
        .rst   (rst),
        .full  (full),
        .wr_en (wr_en_s)
    );

    // Storage array: cleared by reset, one slot written per enabled cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NO_REG; i++) begin
                storage_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NO_REG; i++) begin
                if (wr_en_s[i]) begin
                    storage_r[i] <= input_data_split;
                end else begin
                    storage_r[i] <= storage_r[i];
                end
            end
        end
    end

    assign concatout = storage_r;

endmodule : concatenator

// File: tb/tb_concatenator.sv
// Directed, table-driven bench for concatenator (default build and CONCATENATOR_WRAP_EN build).
module tb_concatenator;
    import concat_pkg::*;

    localparam int N = 128;

    typedef struct {
        concat_word_t din;
        logic         exp_full;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    concat_word_t input_data_split = 8'h00;
    logic         full;
    concat_word_t concatout [0:N-1];

    int nchecks = 0;
    int nerrors = 0;
    vec_t tbl [N];

    concatenator dut (
        .clk              (clk),
        .rst              (rst),
        .input_data_split (input_data_split),
        .full             (full),
        .concatout        (concatout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled at the same point.
    task automatic tick(input concat_word_t d, input logic r);
        rst = r;
        input_data_split = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input int first, input int last, input int exp);
        for (int i = first; i <= last; i++) begin
            chk($sformatf("%s[%0d]", name, i), int'(concatout[i]), exp);
        end
    endtask

    initial begin
        int edges;
        int pulses;
        bit seen;

        for (int i = 0; i < N; i++) begin
            tbl[i].din      = concat_word_t'(i);
            tbl[i].exp_full = (i == N - 1);
        end

        // Random activity, then one reset edge
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) tick(concat_word_t'($urandom_range(255, 0)), 1'b1);
        tick(8'h5C, 1'b0);
        chk("reset_full", int'(full), 0);
        check_all("reset_slot", 0, N - 1, 0);

        // Sequential fill 0x00..0x7F
        for (int i = 0; i < N; i++) begin
            tick(tbl[i].din, 1'b1);
            chk($sformatf("fill_full_e%0d", i), int'(full), int'(tbl[i].exp_full));
            chk($sformatf("fill_slot%0d", i), int'(concatout[i]), int'(tbl[i].din));
        end
        for (int i = 0; i < N; i++) chk($sformatf("fill_final%0d", i), int'(concatout[i]), i);

`ifndef CONCATENATOR_WRAP_EN
        // Blocked writes while full
        for (int i = 0; i < 10; i++) begin
            tick(8'hAA, 1'b1);
            chk($sformatf("blocked_full_c%0d", i), int'(full), 1);
        end
        for (int i = 0; i < N; i++) chk($sformatf("blocked_slot%0d", i), int'(concatout[i]), i);
`else
        // One cycle after the closing write the pulse drops and slot 0 is overwritten
        tick(8'h99, 1'b1);
        chk("wrap_pulse_drop", int'(full), 0);
        chk("wrap_over_slot0", int'(concatout[0]), 8'h99);
`endif

        // Reset mid-fill
        tick(8'h00, 1'b0);
        for (int i = 0; i < 40; i++) tick(concat_word_t'(8'hC0 + i), 1'b1);
        chk("mid_slot39", int'(concatout[39]), 8'hC0 + 39);
        tick(8'h11, 1'b0);
        tick(8'h07, 1'b1);
        chk("mid_slot0", int'(concatout[0]), 8'h07);
        check_all("mid_rest", 1, N - 1, 0);
        chk("mid_full", int'(full), 0);

        // Refill: reset, hold 0x07, count edges to full
        tick(8'h07, 1'b0);
        chk("refill_reset_full", int'(full), 0);
        edges = 0;
        seen = 1'b0;
        while (!seen && edges < 200) begin
            tick(8'h07, 1'b1);
            edges++;
            seen = full;
        end
        chk("refill_edges", edges, N);
        check_all("refill_slot", 0, N - 1, 8'h07);

`ifdef CONCATENATOR_WRAP_EN
        // 129 words, value i on edge i
        tick(8'h00, 1'b0);
        pulses = 0;
        for (int i = 0; i <= N; i++) begin
            tick(concat_word_t'(i), 1'b1);
            if (full) pulses++;
            if (i == N - 1) chk("wrap_full_e127", int'(full), 1);
            if (i == N) chk("wrap_full_e128", int'(full), 0);
        end
        chk("wrap_pulses", pulses, 1);
        chk("wrap_slot0", int'(concatout[0]), 8'h80);
        chk("wrap_slot1", int'(concatout[1]), 8'h01);
`else
        pulses = 0;
        tick(8'h00, 1'b0);
        for (int i = 0; i <= N; i++) begin
            tick(concat_word_t'(8'hFF - i), 1'b1);
            if (full) pulses++;
        end
        chk("sticky_full_edges", pulses, 2);
        chk("sticky_slot0", int'(concatout[0]), 8'hFF);
        chk("sticky_slot127", int'(concatout[N-1]), 8'hFF - (N - 1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule : tb_concatenator
